// File: rtl/wshb_pattern_pkg.sv
// Shared types, CTRL field positions and bar colours for the Wishbone pattern responder.
package wshb_pattern_pkg;

    typedef enum logic [1:0] {BARS, CHECKER, GRAD, SOLID} pattern_e;
    typedef enum logic [1:0] {IDLE, DIV, WAIT, ACK} state_e;

    localparam int CTRL_PAT_LSB  = 0;
    localparam int CTRL_WAIT_LSB = 4;
    localparam int CTRL_RGB_LSB  = 8;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        logic [23:0] c;
        unique case (bar)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wshb_pattern_slave_div.sv
// Pixel index to (x, y) converter: one subtraction of HDISP per cycle.
module pixel_pos_div
    import wshb_pattern_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    localparam int IW = $clog2(HDISP * VDISP),
    localparam int XW = $clog2(HDISP),
    localparam int YW = $clog2(VDISP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [IW-1:0] idx,
    output logic          done,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y
);

    logic [IW-1:0] rem;
    logic [YW-1:0] quo;
    logic          busy;
    logic          fits;

    assign fits = rem < IW'(HDISP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            quo  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= idx;
            quo  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (fits) begin
                busy <= 1'b0;
            end else begin
                rem <= rem - IW'(HDISP);
                quo <= quo + YW'(1);
            end
        end
    end

    assign done = busy && fits;
    assign x    = rem[XW-1:0];
    assign y    = quo;

endmodule

// File: rtl/wshb_pattern_slave.sv
// Wishbone B4 classic responder generating synthetic 24-bit frames for the VGA reader.
// Optional SCROLL_EN: horizontal scroll that advances by one pixel per frame.
module wshb_pattern_slave
    import wshb_pattern_pkg::*;
#(
    parameter int HDISP   = 800,
    parameter int VDISP   = 480,
    parameter int SQ_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic        cyc,
    input  logic        stb,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic [31:0] dat_sm,
    output logic        ack
);

    localparam int NPIX = HDISP * VDISP;
    localparam int IW   = $clog2(NPIX);
    localparam int XW   = $clog2(HDISP);
    localparam int YW   = $clog2(VDISP);

    state_e        state, state_n;
    logic [31:0]   ctrl;
    logic [IW-1:0] idx_exp;
    logic [XW-1:0] x, px, xe, div_x;
    logic [YW-1:0] y, py, div_y;
    logic [7:0]    frame_cnt;
    logic [3:0]    wcnt;
    logic          div_start, div_done, fire, commit;

    logic          req, is_ctrl, in_range, pix_rd, last_pix;
    logic [29:0]   pix_idx;
    logic [IW-1:0] idx;
    logic [3:0]    wait_n;
    logic          unused;

    assign unused   = ^{cti, bte, adr[1:0]};
    assign req      = cyc & stb;
    assign is_ctrl  = adr[31];
    assign pix_idx  = adr[31:2];
    assign idx      = pix_idx[IW-1:0];
    assign in_range = pix_idx < 30'(NPIX);
    assign pix_rd   = !is_ctrl && !we && in_range;
    assign last_pix = idx == IW'(NPIX - 1);
    assign wait_n   = ctrl[CTRL_WAIT_LSB +: 4];

    pixel_pos_div #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .idx   (idx),
        .done  (div_done),
        .x     (div_x),
        .y     (div_y)
    );

    always_comb begin
        state_n   = state;
        div_start = 1'b0;
        fire      = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (pix_rd && idx != idx_exp) begin
                        state_n   = DIV;
                        div_start = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            DIV: begin
                if (!req)          state_n = IDLE;
                else if (div_done) state_n = WAIT;
            end
            WAIT: begin
                if (!req) begin
                    state_n = IDLE;
                end else if (wcnt == wait_n) begin
                    state_n = ACK;
                    fire    = 1'b1;
                end
            end
            ACK: begin
                state_n = IDLE;
                commit  = req;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SCROLL_EN
    logic [7:0]  scroll;
    logic [XW:0] xs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         scroll <= 8'd0;
        else if (commit && pix_rd && last_pix) scroll <= scroll + 8'd1;
    end

    // scroll < HDISP, so a single conditional subtract gives the modulus
    assign xs = {1'b0, px} + (XW+1)'(scroll);
    assign xe = (xs >= (XW+1)'(HDISP)) ? XW'(xs - (XW+1)'(HDISP))
                                       : xs[XW-1:0];
`else
    assign xe = px;
`endif

    logic [XW+2:0] x8;
    logic [2:0]    bar;
    logic [23:0]   colour;
    logic [31:0]   rd_data;

    assign x8  = {xe, 3'b000};
    assign bar = 3'(x8 / (XW+3)'(HDISP));

    always_comb begin
        colour  = 24'h0;
        rd_data = '0;
        unique case (pattern_e'(ctrl[CTRL_PAT_LSB +: 2]))
            BARS:    colour = bar_colour(bar);
            CHECKER: colour = (xe[SQ_LOG2] ^ py[SQ_LOG2]) ? 24'hFFFFFF : 24'h0;
            GRAD:    colour = {xe[7:0], py[7:0], frame_cnt};
            SOLID:   colour = ctrl[CTRL_RGB_LSB +: 24];
            default: colour = 24'h0;
        endcase
        if (is_ctrl)     rd_data = ctrl;
        else if (pix_rd) rd_data = {8'h00, colour};
    end

    // position of the pixel being served: tracker on a hit, divider on a jump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= '0;
            py <= '0;
        end else if (state == IDLE && req) begin
            px <= x;
            py <= y;
        end else if (state == DIV && div_done) begin
            px <= div_x;
            py <= div_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= 1'b0;
            dat_sm    <= '0;
            ctrl      <= '0;
            idx_exp   <= '0;
            x         <= '0;
            y         <= '0;
            frame_cnt <= 8'd0;
            wcnt      <= 4'd0;
        end else begin
            state <= state_n;
            ack   <= fire;
            wcnt  <= (state == WAIT) ? wcnt + 4'd1 : 4'd0;
            if (fire) dat_sm <= we ? 32'h0 : rd_data;
            if (commit && is_ctrl && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) ctrl[8*b +: 8] <= dat_ms[8*b +: 8];
                end
            end
            if (commit && pix_rd) begin
                if (last_pix) begin
                    idx_exp   <= '0;
                    x         <= '0;
                    y         <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    idx_exp <= idx + IW'(1);
                    if (px == XW'(HDISP - 1)) begin
                        x <= '0;
                        y <= py + YW'(1);
                    end else begin
                        x <= px + XW'(1);
                        y <= py;
                    end
                end
            end
        end
    end

endmodule
